// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
// Multi-cycle adder/subtractor. Adds WIDTH-bit operands CHUNK bits per clock,
// keeping the inter-chunk carry in a register. Operands are accepted through a
// valid/ready handshake in IDLE; the result is presented in DONE until the
// consumer takes it. Subtraction is A + ~B + 1 (the +1 enters as the initial
// carry), so carry_out = 1 means "no borrow".

module serial_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   // Guarded so an illegal CHUNK of zero still elaborates far enough to report.
   localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
   localparam int NCHUNK     = (WIDTH / CHUNK_SAFE < 1) ? 1 : WIDTH / CHUNK_SAFE;
   localparam int IDXW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) ||
       ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
      $error("serial_chunk_adder: WIDTH must be >= 1, 1 <= CHUNK <= WIDTH, WIDTH %% CHUNK == 0");
   end

   // Signed two's-complement overflow: both addends share a sign and the
   // result's sign differs from it. B is the already-inverted operand for sub.
   function automatic logic signed_overflow(input logic a_msb,
                                            input logic b_msb,
                                            input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   logic [1:0]        state;
   logic [IDXW-1:0]   idx;
   logic              carry_q;

   // Operands captured at accept; B is stored pre-inverted for subtraction.
   logic [WIDTH-1:0]  a_p0;
   logic [WIDTH-1:0]  b_p0;

   logic [31:0]       chunk_base;
   logic [CHUNK-1:0]  a_chunk;
   logic [CHUNK-1:0]  b_chunk;
   logic [CHUNK:0]    chunk_res;
   logic              last_chunk;
   logic              accept;

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign accept    = in_valid && (state == ST_IDLE);

   // Slice the current chunk of each operand and add it with the running carry.
   always_comb begin
      chunk_base = 32'(idx) * 32'(CHUNK);
      a_chunk    = a_p0[chunk_base +: CHUNK];
      b_chunk    = b_p0[chunk_base +: CHUNK];
      chunk_res  = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry_q);
      last_chunk = (idx == LAST_IDX);
   end

   // Control: state machine, chunk index and inter-chunk carry.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state   <= ST_RUN;
                  idx     <= '0;
                  carry_q <= sub;
               end
            end
            ST_RUN: begin
               carry_q <= chunk_res[CHUNK];
               if (last_chunk) begin
                  state <= ST_DONE;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Operand capture on accept; operands are data and need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0 <= a;
         b_p0 <= sub ? ~b : b;
      end
   end

   // Result: one chunk of sum per RUN cycle, flags on the last chunk.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (state == ST_RUN) begin
         sum[chunk_base +: CHUNK] <= chunk_res[CHUNK-1:0];
         if (last_chunk) begin
            carry_out <= chunk_res[CHUNK];
            overflow  <= signed_overflow(a_p0[WIDTH-1], b_p0[WIDTH-1],
                                         chunk_res[CHUNK-1]);
         end
      end
   end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Testbench for serial_chunk_adder. Six instances with different WIDTH/CHUNK
// share one stimulus bus; each scenario checks the instances it is about.
// Index map: 0 = 1/1, 1 = 8/2, 2 = 8/4, 3 = 32/4, 4 = 32/1, 5 = 32/32.

module tb_serial_chunk_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;

   logic        ordy [6];
   logic        ovld [6];
   logic        oco  [6];
   logic        oov  [6];
   logic [31:0] osum [6];

   logic [0:0]  s_1;
   logic [7:0]  s_82;
   logic [7:0]  s_84;
   logic [31:0] s_324;
   logic [31:0] s_321;
   logic [31:0] s_3232;

   int checks = 0;
   int errors = 0;

   // Results captured by run_op for the scenario tasks to check.
   logic [31:0] res_sum  [6];
   logic        res_co   [6];
   logic        res_ov   [6];
   int          res_lat  [6];
   int          res_bad  [6];
   logic        res_early;
   logic        res_post_rdy;
   logic        res_post_vld;

   always #5 clk = ~clk;

   assign osum[0] = {31'b0, s_1};
   assign osum[1] = {24'b0, s_82};
   assign osum[2] = {24'b0, s_84};
   assign osum[3] = s_324;
   assign osum[4] = s_321;
   assign osum[5] = s_3232;

   serial_chunk_adder #(.WIDTH(1), .CHUNK(1)) u_1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[0]),
      .a(a[0:0]), .b(b[0:0]), .sub(sub), .out_valid(ovld[0]), .out_ready(out_ready),
      .sum(s_1), .carry_out(oco[0]), .overflow(oov[0]));

   serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_82 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[1]),
      .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ovld[1]), .out_ready(out_ready),
      .sum(s_82), .carry_out(oco[1]), .overflow(oov[1]));

   serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_84 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[2]),
      .a(a[7:0]), .b(b[7:0]), .sub(sub), .out_valid(ovld[2]), .out_ready(out_ready),
      .sum(s_84), .carry_out(oco[2]), .overflow(oov[2]));

   serial_chunk_adder #(.WIDTH(32), .CHUNK(4)) u_324 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[3]),
      .a(a), .b(b), .sub(sub), .out_valid(ovld[3]), .out_ready(out_ready),
      .sum(s_324), .carry_out(oco[3]), .overflow(oov[3]));

   serial_chunk_adder #(.WIDTH(32), .CHUNK(1)) u_321 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[4]),
      .a(a), .b(b), .sub(sub), .out_valid(ovld[4]), .out_ready(out_ready),
      .sum(s_321), .carry_out(oco[4]), .overflow(oov[4]));

   serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) u_3232 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ordy[5]),
      .a(a), .b(b), .sub(sub), .out_valid(ovld[5]), .out_ready(out_ready),
      .sum(s_3232), .carry_out(oco[5]), .overflow(oov[5]));

   function automatic int w_of(input int i);
      case (i)
         0:       return 1;
         1, 2:    return 8;
         default: return 32;
      endcase
   endfunction

   function automatic int nc_of(input int i);
      case (i)
         0:       return 1;
         1:       return 4;
         2:       return 2;
         3:       return 8;
         4:       return 32;
         default: return 1;
      endcase
   endfunction

   function automatic bit all_ready();
      for (int i = 0; i < 6; i++) if (ordy[i] !== 1'b1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit all_valid();
      for (int i = 0; i < 6; i++) if (ovld[i] !== 1'b1) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit any_valid();
      for (int i = 0; i < 6; i++) if (ovld[i] !== 1'b0) return 1'b1;
      return 1'b0;
   endfunction

   // Golden model: {carry,sum} = a + (sub ? ~b : b) + sub at width w; returns {ov, co, sum}.
   function automatic logic [33:0] model(input logic [31:0] ai, input logic [31:0] bi,
                                         input logic si, input int w);
      logic [31:0] mask;
      logic [31:0] bb;
      logic [31:0] s;
      logic [63:0] tot;
      logic        c;
      logic        v;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      bb   = (si ? ~bi : bi) & mask;
      tot  = 64'(ai & mask) + 64'(bb) + 64'(si);
      s    = tot[31:0] & mask;
      c    = tot[w];
      v    = (ai[w-1] == bb[w-1]) && (s[w-1] != ai[w-1]);
      return {v, c, s};
   endfunction

   // Drive random values on all inputs that must be ignored outside IDLE.
   task automatic noise();
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
   endtask

   // One transaction on all instances: accept, wait for every result, stall
   // with out_ready low for 'stall' cycles, then hand the results off.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic ts, input int stall);
      int n;
      n = 0;
      while (!all_ready() && n < 60) begin
         @(posedge clk); #1; n++;
      end
      if (!all_ready()) begin
         checks++; errors++;
         $display("FAIL idle_wait: in_ready not all high after %0d cycles", n);
      end
      a = ta; b = tb_v; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      res_early = any_valid() || (ordy[0] !== 1'b0) || (ordy[4] !== 1'b0);
      for (int i = 0; i < 6; i++) begin
         res_lat[i] = 0;
         res_bad[i] = 0;
      end
      n = 0;
      while (!all_valid() && n < 40) begin
         noise();
         @(posedge clk); #1; n++;
         for (int i = 0; i < 6; i++) if (ovld[i] === 1'b1 && res_lat[i] == 0) res_lat[i] = n;
      end
      if (!all_valid()) begin
         checks++; errors++;
         $display("FAIL done_wait: out_valid not all high after %0d cycles", n);
      end
      for (int i = 0; i < 6; i++) begin
         res_sum[i] = osum[i];
         res_co[i]  = oco[i];
         res_ov[i]  = oov[i];
      end
      for (int k = 0; k < stall; k++) begin
         noise();
         @(posedge clk); #1;
         for (int i = 0; i < 6; i++) begin
            if (osum[i] !== res_sum[i] || oco[i] !== res_co[i] || oov[i] !== res_ov[i] ||
                ordy[i] !== 1'b0 || ovld[i] !== 1'b1) res_bad[i]++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready    = 1'b0;
      res_post_rdy = all_ready();
      res_post_vld = any_valid();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (ordy[i] !== 1'b1 || ovld[i] !== 1'b0 || osum[i] !== 32'h0 ||
             oco[i] !== 1'b0 || oov[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state[%0d]: rdy=%b vld=%b sum=%h co=%b ov=%b, want 1 0 0 0 0",
                     i, ordy[i], ovld[i], osum[i], oco[i], oov[i]);
         end
      end
   endtask

   task automatic test_half_adder();
      logic [1:0] ha_exp [4];   // {carry_out, sum} for (a,b) = 00,01,10,11
      ha_exp = '{2'b00, 2'b01, 2'b01, 2'b10};
      for (int k = 0; k < 4; k++) begin
         run_op({31'b0, 1'(k >> 1)}, {31'b0, 1'(k)}, 1'b0, 0);
         checks++;
         if ({res_co[0], res_sum[0][0]} !== ha_exp[k]) begin
            errors++;
            $display("FAIL half_adder[%0d]: {co,sum}=%b%b want %b", k, res_co[0], res_sum[0][0], ha_exp[k]);
         end
         checks++;
         if (res_lat[0] != 1) begin
            errors++;
            $display("FAIL half_adder_latency[%0d]: %0d want 1", k, res_lat[0]);
         end
      end
   endtask

   task automatic test_add8();
      run_op(32'hFF, 32'h01, 1'b0, 0);
      checks++;
      if (res_sum[1] !== 32'h00 || res_co[1] !== 1'b1 || res_ov[1] !== 1'b0) begin
         errors++;
         $display("FAIL add_ff_01: sum=%h co=%b ov=%b want 00 1 0", res_sum[1], res_co[1], res_ov[1]);
      end
      checks++;
      if (res_lat[1] != 4 || res_lat[2] != 2) begin
         errors++;
         $display("FAIL add_latency: w8c2=%0d w8c4=%0d want 4 2", res_lat[1], res_lat[2]);
      end
      checks++;
      if (res_early !== 1'b0) begin
         errors++;
         $display("FAIL accept_edge_outputs: early=%b want 0", res_early);
      end
      run_op(32'h7F, 32'h01, 1'b0, 0);
      checks++;
      if (res_sum[1] !== 32'h80 || res_co[1] !== 1'b0 || res_ov[1] !== 1'b1) begin
         errors++;
         $display("FAIL add_7f_01: sum=%h co=%b ov=%b want 80 0 1", res_sum[1], res_co[1], res_ov[1]);
      end
   endtask

   task automatic test_sub8();
      run_op(32'h05, 32'h07, 1'b1, 0);
      checks++;
      if (res_sum[1] !== 32'hFE || res_co[1] !== 1'b0 || res_ov[1] !== 1'b0) begin
         errors++;
         $display("FAIL sub_05_07: sum=%h co=%b ov=%b want fe 0 0", res_sum[1], res_co[1], res_ov[1]);
      end
      run_op(32'h80, 32'h01, 1'b1, 0);
      checks++;
      if (res_sum[1] !== 32'h7F || res_co[1] !== 1'b1 || res_ov[1] !== 1'b1) begin
         errors++;
         $display("FAIL sub_80_01: sum=%h co=%b ov=%b want 7f 1 1", res_sum[1], res_co[1], res_ov[1]);
      end
   endtask

   task automatic test_backpressure();
      run_op(32'h12, 32'h34, 1'b0, 10);
      checks++;
      if (res_sum[2] !== 32'h46 || res_co[2] !== 1'b0) begin
         errors++;
         $display("FAIL bp_result: sum=%h co=%b want 46 0", res_sum[2], res_co[2]);
      end
      checks++;
      if (res_bad[2] != 0 || res_bad[3] != 0) begin
         errors++;
         $display("FAIL bp_hold: unstable cycles w8c4=%0d w32c4=%0d want 0 0", res_bad[2], res_bad[3]);
      end
      checks++;
      if (res_post_rdy !== 1'b1 || res_post_vld !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", res_post_rdy, res_post_vld);
      end
   endtask

   // out_ready held high from the accept on: it must not shorten RUN.
   task automatic test_latency();
      int n;
      int lat82;
      int lat321;
      logic rdy_after;
      logic vld_after;
      logic [31:0] s82;
      lat82 = 0; lat321 = 0; rdy_after = 1'b0; vld_after = 1'b1; s82 = '1;
      n = 0;
      while (!all_ready() && n < 60) begin
         @(posedge clk); #1; n++;
      end
      a = 32'hFF; b = 32'h01; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while ((lat82 == 0 || lat321 == 0 || n <= lat82) && n < 40) begin
         @(posedge clk); #1; n++;
         if (lat82 != 0 && n == lat82 + 1) begin
            rdy_after = ordy[1];
            vld_after = ovld[1];
         end
         if (ovld[1] === 1'b1 && lat82 == 0) begin
            lat82 = n;
            s82   = osum[1];
         end
         if (ovld[4] === 1'b1 && lat321 == 0) lat321 = n;
      end
      out_ready = 1'b0;
      checks++;
      if (lat82 != 4 || lat321 != 32) begin
         errors++;
         $display("FAIL ready_early_latency: w8c2=%0d w32c1=%0d want 4 32", lat82, lat321);
      end
      checks++;
      if (s82 !== 32'h00) begin
         errors++;
         $display("FAIL ready_early_sum: %h want 00", s82);
      end
      checks++;
      if (rdy_after !== 1'b1 || vld_after !== 1'b0) begin
         errors++;
         $display("FAIL ready_early_handoff: in_ready=%b out_valid=%b want 1 0", rdy_after, vld_after);
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      int seen;
      n = 0;
      while (!all_ready() && n < 60) begin
         @(posedge clk); #1; n++;
      end
      a = 32'h33; b = 32'h11; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (ordy[1] !== 1'b1 || ovld[1] !== 1'b0 || osum[1] !== 32'h0 ||
          oco[1] !== 1'b0 || oov[1] !== 1'b0) begin
         errors++;
         $display("FAIL mid_run_reset: rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0 0 0",
                  ordy[1], ovld[1], osum[1], oco[1], oov[1]);
      end
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (ovld[1] !== 1'b0 || ovld[3] !== 1'b0 || ovld[4] !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL aborted_op_valid: out_valid high for %0d cycles want 0", seen);
      end
      run_op(32'h0A, 32'h05, 1'b0, 0);
      checks++;
      if (res_sum[1] !== 32'h0F || res_co[1] !== 1'b0) begin
         errors++;
         $display("FAIL after_reset_op: sum=%h co=%b want 0f 0", res_sum[1], res_co[1]);
      end
   endtask

   task automatic test_regression();
      logic [31:0] ta;
      logic [31:0] tbv;
      logic        ts;
      logic [33:0] exp;
      for (int t = 0; t < 1000; t++) begin
         ta  = $urandom;
         tbv = $urandom;
         ts  = 1'($urandom_range(0, 1));
         run_op(ta, tbv, ts, int'($urandom_range(0, 3)));
         for (int i = 0; i < 6; i++) begin
            exp = model(ta, tbv, ts, w_of(i));
            checks++;
            if (res_sum[i] !== exp[31:0] || res_co[i] !== exp[32] || res_ov[i] !== exp[33] ||
                res_lat[i] != nc_of(i) || res_bad[i] != 0) begin
               errors++;
               $display("FAIL regress[%0d] inst%0d a=%h b=%h sub=%b: sum=%h co=%b ov=%b lat=%0d bad=%0d want sum=%h co=%b ov=%b lat=%0d",
                        t, i, ta, tbv, ts, res_sum[i], res_co[i], res_ov[i], res_lat[i], res_bad[i],
                        exp[31:0], exp[32], exp[33], nc_of(i));
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_half_adder();
      test_add8();
      test_sub8();
      test_backpressure();
      test_latency();
      test_reset_mid_run();
      test_regression();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
Multi-cycle parametrised adder/subtractor in arithmetics/. It is the sequential successor to the 1-bit half adder. It processes WIDTH-bit operands CHUNK bits per clock and carries between chunks in a register. Operands enter and results leave through valid/ready handshakes. Used where a full-width carry chain is too slow or too large.

Parameters:
WIDTH, 32, operand and result width in bits; must be >= 1.
CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH; WIDTH % CHUNK == 0 (elaboration-time check, $error otherwise).
NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands/mode valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B (two's complement)
out_valid  output  1  result valid; high only in DONE
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, registered
carry_out  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- One clock, synchronous active-high reset. On a rising edge with rst=1:
  - state <= IDLE, chunk index <= 0, carry reg <= 0.
  - sum <= 0, carry_out <= 0, overflow <= 0.
  - Outputs after that edge: out_valid = 0, in_ready = 1.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state; there is no combinational path from inputs to outputs.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when in_valid && in_ready at an edge. At that edge:
  - latch A = a and B' = sub ? ~b : b.
  - carry reg <= sub; index <= 0.
  - sum is not cleared at accept; the previous result stays on sum until overwritten, but out_valid = 0.
- RUN, each edge:
  - {c, s} = A[idx*CHUNK +: CHUNK] + B'[idx*CHUNK +: CHUNK] + carry, computed in CHUNK+1 bits.
  - sum[idx*CHUNK +: CHUNK] <= s; carry <= c; idx <= idx+1.
  - On the edge that processes idx == NCHUNK-1: state <= DONE, carry_out <= c, overflow <= (A[MSB] == B'[MSB]) && (s[CHUNK-1] != A[MSB]).
- Latency: operands accepted at edge k give out_valid=1 after edge k+NCHUNK. CHUNK==WIDTH gives 1 RUN cycle.
- DONE:
  - sum, carry_out and overflow hold stable while out_ready=0 (backpressure of any length).
  - out_ready=1 at an edge -> IDLE.
  - No new accept occurs on the same edge as a result handoff. Minimum initiation interval = NCHUNK+2 cycles.
- Inputs a, b, sub and in_valid are ignored outside IDLE. Changes during RUN/DONE do not affect the result.
- out_ready is ignored outside DONE.
- Reset mid-RUN or mid-DONE: the operation is aborted and no out_valid is produced for it. Outputs take their reset values after the edge.
- Unsigned wrap: the result is modulo 2^WIDTH; carry_out reports the wrap.
- WIDTH=1, CHUNK=1, sub=0: sum/carry_out equal the half-adder truth table.

Test Plan:
- WIDTH=1, CHUNK=1, sub=0, all four (a,b) -> (sum,carry_out) = 00->(0,0), 01->(1,0), 10->(1,0), 11->(0,1); out_valid 1 cycle after accept.
- WIDTH=8, CHUNK=2, add 0xFF+0x01 -> sum=0x00, carry_out=1, overflow=0; out_valid rises exactly 4 cycles after the accept edge. Add 0x7F+0x01 -> 0x80, carry_out=0, overflow=1.
- WIDTH=8, CHUNK=2, sub: 0x05-0x07 -> sum=0xFE, carry_out=0, overflow=0. 0x80-0x01 -> 0x7F, carry_out=1, overflow=1.
- Backpressure: WIDTH=8, CHUNK=4, 0x12+0x34, out_ready held 0 for 10 cycles while a/b/in_valid toggle randomly -> sum=0x46 stable, out_valid=1, in_ready=0 throughout. out_ready=1 -> IDLE and in_ready=1 next cycle.
- Reset mid-RUN: WIDTH=8, CHUNK=2, assert rst for one edge at RUN cycle 2 -> out_valid never rises for that op; after the edge in_ready=1, sum=0, carry_out=0, overflow=0. The next op 0x0A+0x05 gives 0x0F.
- Random regression: WIDTH=32, CHUNK=4 (also CHUNK=1 and CHUNK=32), 1000 random a/b/sub with random out_ready stalls -> every result matches a golden model {carry,sum} = a + (sub?~b:b) + sub, with the overflow rule above and latency NCHUNK.
